// File: rtl/scmp_bus_seq_pkg.sv
// scmp_bus_pak: shared bus-sequencer state type and status-flag bit positions
package scmp_bus_pak;
    typedef enum logic [2:0] {IDLE, BREQ, ADDR, STRB, DONE} BUS_ST_t;
    localparam int FLG_IX_R = 0;
    localparam int FLG_IX_I = 1;
    localparam int FLG_IX_D = 2;
    localparam int FLG_IX_H = 3;
    localparam int CNT_W    = 16;
endpackage

// File: rtl/scmp_bus_seq_if.sv
// scmp_bus_seq_if: core-side single-beat request/acknowledge handshake
interface scmp_bus_seq_if #(parameter int ADDR_W = 16);
    logic              req_i;
    logic              req_we_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [7:0]        req_wdata_i;
    logic [3:0]        req_flags_i;
    logic              ack_o;
    logic              err_o;
    logic [7:0]        rdata_o;
    logic              busy_o;
    modport master (output req_i, req_we_i, req_addr_i, req_wdata_i, req_flags_i,
                    input  ack_o, err_o, rdata_o, busy_o);
    modport slave  (input  req_i, req_we_i, req_addr_i, req_wdata_i, req_flags_i,
                    output ack_o, err_o, rdata_o, busy_o);
endinterface

// File: rtl/scmp_bus_seq_sync.sv
// scmp_sync: DEPTH-stage flop chain synchroniser, async reset to 0
module scmp_sync #(parameter int DEPTH = 2) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [DEPTH-1:0] r_q;
    // shift the asynchronous input through the chain
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_q <= '0;
        else        r_q <= {r_q[DEPTH-2:0], i_d};
    assign o_q = r_q[DEPTH-1];
endmodule

// File: rtl/scmp_bus_seq.sv
// scmp_bus_seq: SC/MP external bus-cycle sequencer (optional HOLD timeout via SCMP_BUS_TIMEOUT_EN)
module scmp_bus_seq
    import scmp_bus_pak::*;
#(
    parameter int ADDR_W    = 16,
    parameter int ADS_CYC   = 1,
    parameter int STRB_CYC  = 2,
    parameter int HOLD_SYNC = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    scmp_bus_seq_if.slave     core,
    input  logic              en_in_i,
    output logic              en_out_o,
    output logic              breq_o,
    output logic [ADDR_W-5:0] addr_o,
    input  logic [7:0]        d_i,
    output logic [7:0]        d_o,
    output logic              d_oe_o,
    output logic              ads_n_o,
    output logic              rd_n_o,
    output logic              wr_n_o,
    input  logic              hold_i
);
    if (ADS_CYC < 1 || STRB_CYC < 1 || HOLD_SYNC < 2 || TIMEOUT < 0) begin : g_bad
        $error("scmp_bus_seq: illegal parameter value");
    end

    BUS_ST_t           r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we, w_we, w_hold, w_load, w_abort, w_strb_min, w_strb_end, w_cap;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [7:0]        r_wdata, w_wdata, r_rdata;
    logic [3:0]        r_flags, w_flags;
    logic              r_ack, r_err, r_busy, r_breq, r_d_oe, r_ads_n, r_rd_n, r_wr_n;
    logic [7:0]        r_d;
    logic [ADDR_W-5:0] r_addr_o;

    scmp_sync #(.DEPTH(HOLD_SYNC)) u_hold_sync (.clk(clk), .rst_n(rst_n), .i_d(hold_i), .o_q(w_hold));

    assign w_strb_min = r_cnt >= CNT_W'(STRB_CYC - 1);
    assign w_strb_end = (w_strb_min && !w_hold) || w_abort;

`ifdef SCMP_BUS_TIMEOUT_EN
    logic [CNT_W-1:0] r_wait;
    assign w_abort = r_state == STRB && w_strb_min && w_hold && r_wait >= CNT_W'(TIMEOUT);
    // count strobe cycles spent past the minimum because of HOLD
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_wait <= '0;
        else        r_wait <= (r_state == STRB && w_strb_min && w_hold) ? (&r_wait ? r_wait : r_wait + 1'b1) : '0;
`else
    assign w_abort = 1'b0;
`endif

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = core.req_i ? BREQ : IDLE;
            BREQ:    w_next = en_in_i ? ADDR : BREQ;
            ADDR:    w_next = r_cnt >= CNT_W'(ADS_CYC - 1) ? STRB : ADDR;
            STRB:    w_next = w_strb_end ? DONE : STRB;
            DONE:    w_next = (core.req_i && en_in_i) ? ADDR : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // a back-to-back cycle uses the fields presented alongside ack
    assign w_load  = (r_state == IDLE && core.req_i) || (r_state == DONE && w_next == ADDR);
    assign w_we    = w_load ? core.req_we_i    : r_we;
    assign w_addr  = w_load ? core.req_addr_i  : r_addr;
    assign w_wdata = w_load ? core.req_wdata_i : r_wdata;
    assign w_flags = w_load ? core.req_flags_i : r_flags;
    assign w_cap   = r_state == STRB && w_strb_end && (!r_we || w_abort);

    // state, phase counter and latched request fields
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : (&r_cnt ? r_cnt : r_cnt + 1'b1);
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_flags <= w_flags;
        end

    // pin and handshake outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_ads_n  <= 1'b1;
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_d_oe   <= 1'b0;
            r_d      <= '0;
            r_addr_o <= '0;
            r_breq   <= 1'b0;
            r_busy   <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 8'h00;
        end else begin
            r_ads_n  <= w_next != ADDR;
            r_rd_n   <= !(w_next == STRB && !w_we);
            r_wr_n   <= !(w_next == STRB && w_we);
            r_d_oe   <= w_next == ADDR || (w_next == STRB && w_we);
            r_d      <= w_next == ADDR ? {w_flags[FLG_IX_H], w_flags[FLG_IX_D], w_flags[FLG_IX_I], w_flags[FLG_IX_R], w_addr[ADDR_W-1 -: 4]}
                      : (w_next == STRB && w_we) ? w_wdata : r_d;
            r_addr_o <= w_next == ADDR ? w_addr[ADDR_W-5:0] : r_addr_o;
            r_breq   <= w_next != IDLE;
            r_busy   <= w_next != IDLE;
            r_ack    <= w_next == DONE && r_state == STRB;
            r_err    <= w_abort;
            r_rdata  <= w_cap ? (w_abort ? 8'hFF : d_i) : r_rdata;
        end

    assign en_out_o     = en_in_i & ~r_breq;
    assign breq_o       = r_breq;
    assign addr_o       = r_addr_o;
    assign d_o          = r_d;
    assign d_oe_o       = r_d_oe;
    assign ads_n_o      = r_ads_n;
    assign rd_n_o       = r_rd_n;
    assign wr_n_o       = r_wr_n;
    assign core.ack_o   = r_ack;
    assign core.err_o   = r_err;
    assign core.rdata_o = r_rdata;
    assign core.busy_o  = r_busy;
endmodule

// File: tb/tb_scmp_bus_seq.sv
// tb_scmp_bus_seq: scoreboard bench for scmp_bus_seq (TIMEOUT=4 scenario under SCMP_BUS_TIMEOUT_EN)
module tb_scmp_bus_seq;
`ifdef SCMP_BUS_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic en_in_i = 1'b1, hold_i = 1'b0;
    logic [7:0] d_i = 8'h00;
    logic en_out_o, breq_o, d_oe_o, ads_n_o, rd_n_o, wr_n_o;
    logic [11:0] addr_o;
    logic [7:0] d_o;
    int checks = 0, errors = 0;

    typedef struct {
        bit         we;
        logic [7:0] rd;
        bit         er;
        int         slen;
        logic [7:0] dads;
        logic [11:0] a;
        logic [7:0] wd;
    } exp_t;
    exp_t sb[$];

    scmp_bus_seq_if #(.ADDR_W(16)) bus ();

    scmp_bus_seq #(.ADDR_W(16), .ADS_CYC(1), .STRB_CYC(2), .HOLD_SYNC(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .core(bus.slave),
        .en_in_i(en_in_i), .en_out_o(en_out_o), .breq_o(breq_o), .addr_o(addr_o),
        .d_i(d_i), .d_o(d_o), .d_oe_o(d_oe_o),
        .ads_n_o(ads_n_o), .rd_n_o(rd_n_o), .wr_n_o(wr_n_o), .hold_i(hold_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", n, act, exp);
        end
    endtask

    task automatic bus_op(input bit we, input logic [15:0] a, input logic [7:0] wd, input logic [3:0] fl,
                          input logic [7:0] dv, input bit dinc, input int hf, input int ht, input int en0,
                          input bit keep, input int lat, input int slen, input logic [7:0] rd, input bit er);
        exp_t e;
        int   k;
        bit   bad;
        e = '{we: we, rd: rd, er: er, slen: slen, dads: {fl, a[15:12]}, a: a[11:0], wd: wd};
        sb.push_back(e);
        bus.req_i = 1'b1; bus.req_we_i = we; bus.req_addr_i = a; bus.req_wdata_i = wd; bus.req_flags_i = fl;
        d_i = dv; hold_i = (0 >= hf && 0 < ht); en_in_i = (0 >= en0);
        k = 0; bad = 1'b0;
        do begin
            @(negedge clk);
            k++;
            d_i = dinc ? dv + 8'(k) : dv;
            hold_i = (k >= hf && k < ht);
            en_in_i = (k >= en0);
            if (!breq_o || !bus.busy_o) bad = 1'b1;
            if (en0 > 0 && k <= en0 && (en_out_o || !ads_n_o || !rd_n_o || !wr_n_o)) bad = 1'b1;
            if (en0 > 0 && k == en0 + 1 && ads_n_o) bad = 1'b1;
        end while (!bus.ack_o && k < 100);
        chk("ack_latency", 64'(k), 64'(lat));
        chk("breq_busy_arbitration", 64'(bad), 64'd0);
        if (!keep) begin
            bus.req_i = 1'b0;
            hold_i = 1'b0;
        end
    endtask

    // monitor: accumulates pin activity per cycle and checks it against the scoreboard on each ack
    initial begin
        exp_t e;
        int n_ads, n_rd, n_wr;
        logic [7:0] c_d, c_wd;
        logic [11:0] c_a;
        bit c_oe, drv_bad, ovl;
        n_ads = 0; n_rd = 0; n_wr = 0; c_d = '0; c_wd = '0; c_a = '0; c_oe = 0; drv_bad = 0; ovl = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                n_ads = 0; n_rd = 0; n_wr = 0; drv_bad = 0; ovl = 0;
            end else begin
                if (!ads_n_o) begin n_ads++; c_d = d_o; c_a = addr_o; c_oe = d_oe_o; end
                if (!rd_n_o) begin n_rd++; if (d_oe_o) drv_bad = 1; end
                if (!wr_n_o) begin n_wr++; c_wd = d_o; if (!d_oe_o) drv_bad = 1; end
                if ($countones({~ads_n_o, ~rd_n_o, ~wr_n_o}) > 1) ovl = 1;
                if (bus.ack_o) begin
                    chk("ack_expected", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("err_o", 64'(bus.err_o), 64'(e.er));
                        chk("rdata_o", 64'(bus.rdata_o), 64'(e.rd));
                        chk("ads_len", 64'(n_ads), 64'd1);
                        chk("ads_d_o", 64'(c_d), 64'(e.dads));
                        chk("ads_addr_o", 64'(c_a), 64'(e.a));
                        chk("ads_d_oe", 64'(c_oe), 64'd1);
                        chk("strobe_drive", 64'(drv_bad), 64'd0);
                        chk("strobe_overlap", 64'(ovl), 64'd0);
                        chk("other_strobe", 64'(e.we ? n_rd : n_wr), 64'd0);
                        if (e.slen >= 0) chk("strobe_len", 64'(e.we ? n_wr : n_rd), 64'(e.slen));
                        if (e.we) chk("write_d_o", 64'(c_wd), 64'(e.wd));
                    end
                    n_ads = 0; n_rd = 0; n_wr = 0; drv_bad = 0; ovl = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=%0d expected=0", 1);
        $fatal(1);
    end

    initial begin
        int k;
        bus.req_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0; bus.req_flags_i = '0;
        repeat (2) @(negedge clk);
        chk("reset_state",
            {ads_n_o, rd_n_o, wr_n_o, d_oe_o, breq_o, bus.ack_o, bus.err_o, bus.busy_o, en_out_o, bus.rdata_o, addr_o, d_o},
            {9'b111000001, 8'h00, 12'h000, 8'h00});
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_en_out", 64'(en_out_o), 64'd1);
        bus_op(0, 16'h5A3C, 8'h00, 4'b0101, 8'h7E, 0, 0, 0, 0, 0, 5, 2, 8'h7E, 0);
        @(negedge clk);
        bus_op(1, 16'h1234, 8'hC3, 4'b1000, 8'h00, 0, 0, 0, 0, 0, 5, 2, 8'h7E, 0);
        @(negedge clk);
`ifndef SCMP_BUS_TIMEOUT_EN
        bus_op(0, 16'hF00F, 8'h00, 4'b1111, 8'hA0, 1, 2, 8, 0, 0, 11, 8, 8'hAA, 0);
        @(negedge clk);
`endif
        bus_op(0, 16'h0001, 8'h00, 4'b0010, 8'h3C, 0, 0, 0, 10, 0, 14, 2, 8'h3C, 0);
        @(negedge clk);
        bus_op(1, 16'hABCD, 8'h5A, 4'b0001, 8'h00, 0, 0, 0, 0, 1, 5, 2, 8'h3C, 0);
        bus_op(0, 16'h8765, 8'h00, 4'b0100, 8'h96, 0, 0, 0, 0, 0, 4, 2, 8'h96, 0);
        @(negedge clk);
        chk("b2b_release", 64'({breq_o, bus.busy_o}), 64'd0);
        bus.req_i = 1'b1; bus.req_we_i = 1'b0; bus.req_addr_i = 16'h4444; bus.req_flags_i = 4'b0000;
        k = 0;
        do begin @(negedge clk); k++; end while (rd_n_o && k < 50);
        chk("reach_strobe", 64'(rd_n_o), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {ads_n_o, rd_n_o, wr_n_o, d_oe_o, breq_o, bus.ack_o, bus.busy_o, bus.rdata_o},
            {7'b1110000, 8'h00});
        bus.req_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef SCMP_BUS_TIMEOUT_EN
        bus_op(0, 16'h2468, 8'h00, 4'b0011, 8'h77, 0, 0, 1000, 0, 0, 9, 6, 8'hFF, 1);
        @(negedge clk);
`endif
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
